// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module : aes_pkg
// Purpose: Shared AES-128 key-schedule definitions: round count, key type,
//          controller state encoding, round-constant table and its lookup.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  // AES-128 only.
  localparam int NR = 10;

  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_EXPAND  = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // Round constants for rounds 1..10 (entry 0 is round 1).
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rcon word for round r (1..10); any other r yields zero.
  function automatic logic [31:0] rcon_word(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (r == 4'(i)) rc = RCON[i-1];
    end
    return {rc, 24'h000000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox_word.sv
//------------------------------------------------------------------------------
// Module : aes_sbox_word
// Purpose: Combinational AES SubWord - four parallel S-box byte lookups.
// Ports  : word      in  32  word to substitute
//          sub_word  out 32  S-box applied to every byte of word
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_sbox_word (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign sub_word[8*i +: 8] = SBOX[word[8*i +: 8]];
  end

endmodule

`default_nettype wire

// File: rtl/key_sched_ctrl.sv
//------------------------------------------------------------------------------
// Module : key_sched_ctrl
// Purpose: Iterative AES-128 key expansion. Presents round keys 0..10 one at a
//          time over a valid/ready handshake, computing each next key in a
//          single EXPAND cycle, then pulses done.
// Ports  : clk       in   1    clock, rising edge
//          rst_n     in   1    asynchronous active-low reset
//          start     in   1    begin expansion of key_in (IDLE only)
//          key_in    in   128  cipher key, w0 = [127:96]
//          abort     in   1    cancel expansion in progress
//          rk_ready  in   1    consumer accepts rk_out
//          busy      out  1    not IDLE
//          rk_valid  out  1    rk_out/rk_round valid
//          rk_round  out  4    round index of rk_out
//          rk_out    out  128  current round key
//          done      out  1    one-cycle pulse after round-10 key accepted
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_sched_ctrl #(
  // Only 10 (AES-128) is supported.
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  input  logic         rk_ready,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_pkg::state_t state, state_next;
  aes_pkg::key_t   key_reg, key_next;
  logic [3:0]      round_reg;
  logic [31:0]     rot_w3, sub_w3, t_word;
  logic [31:0]     w0n, w1n, w2n, w3n;
  logic            load_key, step_key;

  // Next-key datapath, always computed from the current key register.
  assign rot_w3 = {key_reg[23:0], key_reg[31:24]};

  aes_sbox_word u_sbox (
    .word     (rot_w3),
    .sub_word (sub_w3)
  );

  // Rcon is indexed by the round being produced, i.e. round_reg + 1.
  assign t_word   = sub_w3 ^ aes_pkg::rcon_word(round_reg + 4'd1);
  assign w0n      = key_reg[127:96] ^ t_word;
  assign w1n      = key_reg[95:64]  ^ w0n;
  assign w2n      = key_reg[63:32]  ^ w1n;
  assign w3n      = key_reg[31:0]   ^ w2n;
  assign key_next = {w0n, w1n, w2n, w3n};

  // Abort wins over start in IDLE and over the step in EXPAND.
  assign load_key = (state == aes_pkg::ST_IDLE)   && start && !abort;
  assign step_key = (state == aes_pkg::ST_EXPAND) && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= aes_pkg::ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      aes_pkg::ST_IDLE: begin
        if (start && !abort) state_next = aes_pkg::ST_PRESENT;
      end
      aes_pkg::ST_PRESENT: begin
        if (abort)
          state_next = aes_pkg::ST_IDLE;
        else if (rk_ready)
          state_next = (round_reg == LAST_ROUND) ? aes_pkg::ST_FINISH : aes_pkg::ST_EXPAND;
      end
      aes_pkg::ST_EXPAND: begin
        state_next = abort ? aes_pkg::ST_IDLE : aes_pkg::ST_PRESENT;
      end
      aes_pkg::ST_FINISH: begin
        state_next = aes_pkg::ST_IDLE;
      end
      default: state_next = aes_pkg::ST_IDLE;
    endcase
  end

  // Output decode (Moore)
  always_comb begin
    busy     = (state != aes_pkg::ST_IDLE);
    rk_valid = (state == aes_pkg::ST_PRESENT);
    done     = (state == aes_pkg::ST_FINISH);
  end

  // Key and round registers. EXPAND is only entered with round_reg < LAST_ROUND,
  // so the increment can never pass the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= '0;
      round_reg <= 4'd0;
    end else if (load_key) begin
      key_reg   <= key_in;
      round_reg <= 4'd0;
    end else if (step_key) begin
      key_reg   <= key_next;
      round_reg <= round_reg + 4'd1;
    end
  end

  assign rk_out   = key_reg;
  assign rk_round = round_reg;

endmodule

`default_nettype wire

// File: tb/tb_key_sched_ctrl.sv
`default_nettype none

module tb_key_sched_ctrl;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] F_R3   = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] F_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R2   = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K_ALT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Results collected by run_full
  logic [127:0] seen [0:10];
  int done_cyc, done_cnt, hs_cnt, stall_bad;

  key_sched_ctrl #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .abort    (abort),
    .rk_ready (rk_ready),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an expansion of k and consumes keys, holding rk_ready low for
  // stall_len cycles when round stall_round is first presented.
  task automatic run_full(input logic [127:0] k, input int stall_round, input int stall_len);
    int hold;
    logic [127:0] hold_key;
    hold = 0; hold_key = '0;
    done_cyc = -1; done_cnt = 0; hs_cnt = 0; stall_bad = 0;
    for (int i = 0; i <= 10; i++) seen[i] = '0;
    key_in = k; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      rk_ready = 1'b1;
      if (rk_valid && int'(rk_round) == stall_round && hold <= stall_len) begin
        if (hold == 0) hold_key = rk_out;
        else if (rk_out !== hold_key) stall_bad++;
        if (hold < stall_len) rk_ready = 1'b0;
        hold++;
      end
      if (rk_valid && rk_ready) begin
        seen[rk_round] = rk_out;
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      tick();
    end
    rk_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = K_FIPS;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rk_round !== 4'd0) begin bad++; $display("FAIL reset_round: got %0d want 0", rk_round); end
    total++; if (rk_out !== 128'h0) begin bad++; $display("FAIL reset_out: got %h want 0", rk_out); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    // start on the first edge after release must be honoured
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (rk_valid !== 1'b1) begin bad++; $display("FAIL first_start_valid: got %b want 1", rk_valid); end
    total++; if (rk_out !== K_FIPS) begin bad++; $display("FAIL first_start_key: got %h want %h", rk_out, K_FIPS); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_fips_vector();
    run_full(K_FIPS, -1, 0);
    total++; if (seen[0] !== K_FIPS) begin bad++; $display("FAIL fips_r0: got %h want %h", seen[0], K_FIPS); end
    total++; if (seen[1] !== F_R1) begin bad++; $display("FAIL fips_r1: got %h want %h", seen[1], F_R1); end
    total++; if (seen[2] !== F_R2) begin bad++; $display("FAIL fips_r2: got %h want %h", seen[2], F_R2); end
    total++; if (seen[3] !== F_R3) begin bad++; $display("FAIL fips_r3: got %h want %h", seen[3], F_R3); end
    total++; if (seen[10] !== F_R10) begin bad++; $display("FAIL fips_r10: got %h want %h", seen[10], F_R10); end
    total++; if (hs_cnt !== 11) begin bad++; $display("FAIL fips_handshakes: got %0d want 11", hs_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL fips_done_count: got %0d want 1", done_cnt); end
    total++; if (done_cyc !== 21) begin bad++; $display("FAIL fips_done_cycle: got %0d want 21", done_cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fips_idle_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    run_full(K_FIPS, 4, 5);
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
    total++; if (done_cyc !== 26) begin bad++; $display("FAIL stall_done_cycle: got %0d want 26", done_cyc); end
    total++; if (seen[3] !== F_R3) begin bad++; $display("FAIL stall_r3: got %h want %h", seen[3], F_R3); end
    total++; if (seen[10] !== F_R10) begin bad++; $display("FAIL stall_r10: got %h want %h", seen[10], F_R10); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int found, dones;
    found = 0; dones = 0;
    key_in = K_FIPS; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rk_valid && rk_round == 4'd6) begin found = 1; break; end
      tick();
    end
    total++; if (found !== 1) begin bad++; $display("FAIL abort_reach_r6: got %0d want 1", found); end
    abort = 1'b1;   // with rk_ready still high: abort must win
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", rk_valid); end
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      tick();
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    // abort together with start in IDLE: start ignored
    start = 1'b1; abort = 1'b1; key_in = K_ALT;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_abort_start: got busy=%b want 0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (rk_valid !== 1'b1) begin bad++; $display("FAIL restart_valid: got %b want 1", rk_valid); end
    total++; if (rk_round !== 4'd0) begin bad++; $display("FAIL restart_round: got %0d want 0", rk_round); end
    total++; if (rk_out !== K_ALT) begin bad++; $display("FAIL restart_key: got %h want %h", rk_out, K_ALT); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    int found, valids;
    found = 0; valids = 0;
    key_in = K_FIPS; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rk_valid && rk_round == 4'd3) begin found = 1; break; end
      tick();
    end
    tick();   // now in EXPAND
    total++; if (found !== 1 || rk_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_in_expand: got found=%0d valid=%b busy=%b want 1 0 1", found, rk_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    total++; if (rk_round !== 4'd0) begin bad++; $display("FAIL arst_round: got %0d want 0", rk_round); end
    total++; if (rk_out !== 128'h0) begin bad++; $display("FAIL arst_out: got %h want 0", rk_out); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rk_valid || busy) valids++;
    end
    total++; if (valids !== 0) begin bad++; $display("FAIL arst_stays_idle: got %0d active cycles want 0", valids); end
  endtask

  task automatic test_start_held();
    int valids, done_at;
    valids = 0; done_at = -1;
    key_in = K_FIPS; start = 1'b1; rk_ready = 1'b1;
    tick();
    for (int c = 0; c < 22; c++) begin
      if (rk_valid) valids++;
      if (done && done_at < 0) done_at = c;
      tick();
    end
    total++; if (valids !== 11) begin bad++; $display("FAIL held_valids: got %0d want 11", valids); end
    total++; if (done_at !== 21) begin bad++; $display("FAIL held_done: got %0d want 21", done_at); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_idle: got busy=%b want 0", busy); end
    tick();
    start = 1'b0;
    total++; if (rk_valid !== 1'b1 || rk_round !== 4'd0) begin
      bad++; $display("FAIL held_second_start: got valid=%b round=%0d want 1 0", rk_valid, rk_round);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_zero_key();
    run_full(128'h0, -1, 0);
    total++; if (seen[1] !== Z_R1) begin bad++; $display("FAIL zero_r1: got %h want %h", seen[1], Z_R1); end
    total++; if (seen[2] !== Z_R2) begin bad++; $display("FAIL zero_r2: got %h want %h", seen[2], Z_R2); end
    total++; if (seen[10] !== Z_R10) begin bad++; $display("FAIL zero_r10: got %h want %h", seen[10], Z_R10); end
    total++; if (done_cyc !== 21) begin bad++; $display("FAIL zero_done_cycle: got %0d want 21", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_fips_vector();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_held();
    test_zero_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
